ahfp_addsub_scheduler: RTL and testbench
========================================

AHFP_ADDSUB_SCHEDULER -- requirements
Module: ahfp_addsub_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 1: cycles from fp_valid high to the matching fp_result being valid at the shared add/sub unit.
REQ-002 SHALL have parameter CNT_W, default 3: width of inflight; SHALL satisfy 2^CNT_W > LATENCY+2.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  requester n presents an operation.
REQ-006 a0, b0, a1, b1  input  32 each  IEEE-754 single operands for requester n.
REQ-007 sub0, sub1  input  1 each  1 = compute a-b; 0 = compute a+b.
REQ-008 gnt0, gnt1  output  1 each  combinational grant; operands are consumed in the cycle reqn&gntn.
REQ-009 rsp_valid0, rsp_valid1  output  1 each  one-cycle pulse; result for requester n is on rsp_data.
REQ-010 rsp_data  output  32  registered result, shared by both requesters.
REQ-011 fp_dataa, fp_datab  output  32 each  registered operands to the shared add/sub unit.
REQ-012 fp_valid  output  1  an operation is issued on fp_dataa/fp_datab this cycle.
REQ-013 fp_result  input  32  unit result, valid exactly LATENCY cycles after fp_valid.
REQ-014 inflight  output  CNT_W  operations issued and not yet returned on rsp_valid*.

Function
REQ-015 Arbitration SHALL be round-robin with a 1-bit priority pointer; a lone requester is granted immediately.
REQ-016 At most one grant per cycle; gnt0 and gnt1 SHALL never both be high.
REQ-017 If both requests are high, the grant SHALL go to the pointer's requester; after any grant, the pointer SHALL point to the other requester.
REQ-018 With no grant, the pointer SHALL hold.
REQ-019 gntn SHALL be 0 whenever reqn is 0.
REQ-020 Grant at cycle T: fp_dataa=an and fp_valid=1 at T+1.
REQ-020a fp_datab at T+1 SHALL be bn with bit 31 inverted when subn=1, else bn unchanged.
REQ-021 A requester holding reqn high after its grant SHALL be treated as issuing a new operation; requesters deassert or change operands after gntn.
REQ-022 Issue path SHALL be fully pipelined, no backpressure; one issue per cycle is sustainable indefinitely.
REQ-023 Each issue SHALL push a requester-ID tag into a valid/tag shift pipeline of depth LATENCY+1, aligned to fp_result.
REQ-024 At T+1+LATENCY, rsp_data SHALL register fp_result; at T+2+LATENCY, rsp_validn SHALL pulse for the tagged requester.
REQ-025 Responses SHALL return in issue order, exactly one per grant; rsp_valid0 and rsp_valid1 SHALL never both be high.
REQ-026 rsp_data SHALL hold its last value when no rsp_valid is high.
REQ-027 inflight SHALL increment on a grant and decrement on a response; both in one cycle leaves it unchanged. Maximum value is LATENCY+2.
REQ-028 fp_valid=0 cycles SHALL hold fp_dataa/fp_datab at their previous values.
REQ-029 No arithmetic SHALL be performed in this block beyond the sign-bit inversion; NaN/Inf/zero pass through unchanged.

Reset
REQ-030 While reset=1, the block SHALL force pointer=0 and fp_valid=0, clear all tag-valid bits, and set inflight=0.
REQ-031 While reset=1, the block SHALL set rsp_valid0/1=0, rsp_data=0 and fp_dataa=fp_datab=0.
REQ-032 While reset=1, gnt0 and gnt1 SHALL be 0.
REQ-033 Reset mid-operation SHALL drop all in-flight operations; no rsp_valid SHALL pulse for any operation issued before reset.
REQ-034 The first cycle after reset deasserts SHALL grant normally.

Verification (LATENCY=1)
REQ-035 Single add: req0=1 for one cycle, a0=0x3F800000, b0=0x40000000, sub0=0 -> gnt0 at T; fp_valid at T+1 with fp_datab=0x40000000; rsp_valid0 at T+3, rsp_data=0x40400000.
REQ-036 Subtract: req1, a1=0x40400000, b1=0x3F800000, sub1=1 -> fp_datab=0xBF800000; rsp_valid1 at T+3 with rsp_data=0x40000000.
REQ-037 Contention: req0 and req1 held high for 4 cycles from reset -> grant order 0,1,0,1; rsp_valid order 0,1,0,1; inflight peaks at 3.
REQ-038 Back-to-back: req0 high 10 cycles -> 10 grants and 10 consecutive rsp_valid0 pulses; inflight steady at 3 while the stream is steady.
REQ-039 Reset mid-flight: issue on req0, assert reset at T+1 for one cycle -> no rsp_valid0 ever; inflight=0 after reset.
REQ-040 Idle: no requests -> gnt, fp_valid and rsp_valid stay 0; pointer unchanged (next simultaneous request grants 0 after reset).

Source files
------------

// File: rtl/ahfp_addsub_scheduler_if.sv
// ahfp_addsub_scheduler_if: requester, response and add/sub-unit signals of the scheduler
interface ahfp_addsub_scheduler_if #(
    parameter int CNT_W = 3
);
    logic             req0, req1;
    logic [31:0]      a0, b0, a1, b1;
    logic             sub0, sub1;
    logic             gnt0, gnt1;
    logic             rsp_valid0, rsp_valid1;
    logic [31:0]      rsp_data;
    logic [31:0]      fp_dataa, fp_datab;
    logic             fp_valid;
    logic [31:0]      fp_result;
    logic [CNT_W-1:0] inflight;
    modport master (
        output req0, req1, a0, b0, a1, b1, sub0, sub1, fp_result,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, fp_dataa, fp_datab, fp_valid, inflight
    );
    modport slave (
        input  req0, req1, a0, b0, a1, b1, sub0, sub1, fp_result,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, fp_dataa, fp_datab, fp_valid, inflight
    );
endinterface

// File: rtl/ahfp_addsub_scheduler.sv
// ahfp_addsub_scheduler: round-robin sharing of one pipelined fp add/sub unit between two requesters
module ahfp_addsub_scheduler #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 3
) (
    input logic clk,
    input logic reset,
    ahfp_addsub_scheduler_if.slave bus
);
    logic             ptr_q, ptr_d;
    logic             gnt0, gnt1, any_gnt, rsp_any;
    logic [LATENCY:0] vld_q, vld_d, tag_q, tag_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [31:0]      dataa_q, datab_q, rsp_data_q;
    logic             fp_valid_q, rsp_valid0_q, rsp_valid1_q;
    always_comb begin
        gnt0       = ~reset & bus.req0 & (~bus.req1 | ~ptr_q);
        gnt1       = ~reset & bus.req1 & (~bus.req0 | ptr_q);
        any_gnt    = gnt0 | gnt1;
        rsp_any    = rsp_valid0_q | rsp_valid1_q;
        ptr_d      = gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr_q;
        // stage k of the tag pipeline lines up with fp_result at stage LATENCY
        vld_d      = (LATENCY+1)'({vld_q, any_gnt});
        tag_d      = (LATENCY+1)'({tag_q, gnt1});
        inflight_d = inflight_q + CNT_W'(any_gnt) - CNT_W'(rsp_any);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= 1'b0;
            vld_q        <= '0;
            tag_q        <= '0;
            inflight_q   <= '0;
            fp_valid_q   <= 1'b0;
            dataa_q      <= '0;
            datab_q      <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            vld_q        <= vld_d;
            tag_q        <= tag_d;
            inflight_q   <= inflight_d;
            fp_valid_q   <= any_gnt;
            if (any_gnt) begin
                dataa_q <= gnt1 ? bus.a1 : bus.a0;
                datab_q <= gnt1 ? {bus.b1[31] ^ bus.sub1, bus.b1[30:0]}
                                : {bus.b0[31] ^ bus.sub0, bus.b0[30:0]};
            end
            rsp_valid0_q <= vld_q[LATENCY] & ~tag_q[LATENCY];
            rsp_valid1_q <= vld_q[LATENCY] & tag_q[LATENCY];
            if (vld_q[LATENCY]) rsp_data_q <= bus.fp_result;
        end
    end
    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.fp_valid   = fp_valid_q;
    assign bus.fp_dataa   = dataa_q;
    assign bus.fp_datab   = datab_q;
    assign bus.rsp_valid0 = rsp_valid0_q;
    assign bus.rsp_valid1 = rsp_valid1_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.inflight   = inflight_q;
endmodule

// File: tb/tb_ahfp_addsub_scheduler.sv
// tb_ahfp_addsub_scheduler: directed stimulus with scoreboard queues checked by a negedge monitor
module tb_ahfp_addsub_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    ahfp_addsub_scheduler_if #(.CNT_W(3)) bus();
    ahfp_addsub_scheduler #(.LATENCY(1), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          gc;
    } op_t;
    op_t         fpq[$];
    op_t         rspq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          peak = 0;
    int          n_inf;
    bit          mon_on = 1'b0;
    logic [31:0] last_data = '0;
    // stand-in add/sub unit: known vectors give true IEEE results, others a fixed scramble
    function automatic logic [31:0] fpu(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        return a ^ {b[15:0], b[31:16]};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.fp_result <= fpu(bus.fp_dataa, bus.fp_datab);
    end
    always @(negedge clk) if (mon_on) begin
        while (fpq.size() > 0 && fpq[0].gc + 1 < cyc) begin
            chk("fp_valid_due", 32'(0), 32'(1));
            void'(fpq.pop_front());
        end
        if (bus.fp_valid) begin
            if (fpq.size() == 0) chk("fp_valid_unexpected", 32'(1), 32'(0));
            else begin
                chk("fp_dataa", bus.fp_dataa, fpq[0].a);
                chk("fp_datab", bus.fp_datab, fpq[0].b);
                chk("fp_cycle", 32'(cyc), 32'(fpq[0].gc + 1));
                void'(fpq.pop_front());
            end
        end
        n_inf = 0;
        foreach (rspq[i]) if (rspq[i].gc < cyc) n_inf++;
        chk("inflight", 32'(bus.inflight), 32'(n_inf));
        if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
        chk("rsp_exclusive", 32'(bus.rsp_valid0 & bus.rsp_valid1), 32'(0));
        while (rspq.size() > 0 && rspq[0].gc + 3 < cyc) begin
            chk("rsp_valid_due", 32'(0), 32'(1));
            void'(rspq.pop_front());
        end
        if (bus.rsp_valid0 | bus.rsp_valid1) begin
            if (rspq.size() == 0) chk("rsp_valid_unexpected", 32'(1), 32'(0));
            else begin
                chk("rsp_id", 32'(bus.rsp_valid1), 32'(rspq[0].id));
                chk("rsp_data", bus.rsp_data, rspq[0].res);
                chk("rsp_cycle", 32'(cyc), 32'(rspq[0].gc + 3));
                last_data = rspq[0].res;
                void'(rspq.pop_front());
            end
        end else chk("rsp_hold", bus.rsp_data, last_data);
    end
    task automatic push(input logic id, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.id = id;
        o.a = a;
        o.b = b;
        o.res = fpu(a, b);
        o.gc = cyc;
        fpq.push_back(o);
        rspq.push_back(o);
    endtask
    task automatic step(input logic r0, input logic r1, input logic s0, input logic s1,
                        input logic [31:0] xa0, input logic [31:0] xb0,
                        input logic [31:0] xa1, input logic [31:0] xb1,
                        input logic eg0, input logic eg1);
        bus.req0 = r0;
        bus.req1 = r1;
        bus.sub0 = s0;
        bus.sub1 = s1;
        bus.a0 = xa0;
        bus.b0 = xb0;
        bus.a1 = xa1;
        bus.b1 = xb1;
        #3;
        chk("gnt0", 32'(bus.gnt0), 32'(eg0));
        chk("gnt1", 32'(bus.gnt1), 32'(eg1));
        if (eg0) push(1'b0, xa0, s0 ? {~xb0[31], xb0[30:0]} : xb0);
        if (eg1) push(1'b1, xa1, s1 ? {~xb1[31], xb1[30:0]} : xb1);
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
    endtask
    initial begin
        bus.req0 = 0;
        bus.req1 = 0;
        bus.sub0 = 0;
        bus.sub1 = 0;
        bus.a0 = '0;
        bus.b0 = '0;
        bus.a1 = '0;
        bus.b1 = '0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        chk("reset_fp_valid", 32'(bus.fp_valid), 32'(0));
        chk("reset_fp_dataa", bus.fp_dataa, 32'h0);
        chk("reset_fp_datab", bus.fp_datab, 32'h0);
        chk("reset_rsp_data", bus.rsp_data, 32'h0);
        chk("reset_rsp_valid", 32'({bus.rsp_valid1, bus.rsp_valid0}), 32'(0));
        chk("reset_inflight", 32'(bus.inflight), 32'(0));
        step(1, 1, 0, 0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0);
        reset = 1'b0;
        peak = 0;
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 1, 32'h10000000 + i, 32'h20000000 + i, 32'h30000000 + i, 32'h40000000 + i,
                 i % 2 == 0, i % 2 == 1);
        idle(6);
        chk("inflight_peak", 32'(peak), 32'(3));
        step(1, 0, 0, 0, 32'h3F800000, 32'h40000000, '0, '0, 1, 0);
        idle(5);
        step(0, 1, 0, 1, '0, '0, 32'h40400000, 32'h3F800000, 0, 1);
        idle(5);
        for (int i = 0; i < 10; i++) begin
            if (i == 6) chk("inflight_steady", 32'(bus.inflight), 32'(3));
            step(1, 0, i[0], 0, 32'hA0000000 + i, 32'h0B000000 + (i << 4), '0, '0, 1, 0);
        end
        idle(5);
        step(0, 1, 0, 1, '0, '0, 32'h7F800000, 32'h7FC00000, 0, 1);
        idle(5);
        step(1, 0, 0, 0, 32'hC0000000, 32'h00000000, '0, '0, 1, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
        reset = 1'b0;
        fpq.delete();
        rspq.delete();
        last_data = '0;
        chk("inflight_after_reset", 32'(bus.inflight), 32'(0));
        idle(6);
        step(1, 1, 1, 0, 32'h5A5A5A5A, 32'h80000000, 32'h12345678, 32'h87654321, 1, 0);
        step(1, 1, 0, 0, 32'h5A5A5A5A, 32'h80000000, 32'h12345678, 32'h87654321, 0, 1);
        idle(6);
        chk("fp_queue_drained", 32'(fpq.size()), 32'(0));
        chk("rsp_queue_drained", 32'(rspq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
